// File: rtl/prog_encoder_if.sv
// Mnemonic beat stream into the program encoder: valid/ready handshake with
// a 4-bit mnemonic, a 6-bit operand and an end-of-program marker.
interface prog_encoder_if;
   logic       in_valid_i;
   logic       in_ready_o;
   logic [3:0] mnem_i;
   logic [5:0] opnd_i;
   logic       last_i;

   modport master (
      output in_valid_i,
      output mnem_i,
      output opnd_i,
      output last_i,
      input  in_ready_o
   );

   modport slave (
      input  in_valid_i,
      input  mnem_i,
      input  opnd_i,
      input  last_i,
      output in_ready_o
   );
endinterface

// File: rtl/prog_encoder.sv
// Program loader: encodes mnemonic beats into 9-bit instructions and writes
// them to consecutive instruction-memory addresses starting at start_addr_i.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | after reset, waiting for start_i
//   S_RUN  | accepting beats, writing legal ones at ptr
//   S_DONE | last beat seen, load complete, waiting for start_i
//   S_FULL | top address written without last, load halted
module prog_encoder #(
   parameter int          ADDR_W    = 10,
   parameter int unsigned START_DEF = 0
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   prog_encoder_if.slave     beat,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [8:0]        mem_data_o,
   output logic              done_o,
   output logic              full_o,
   output logic              err_o,
   output logic [ADDR_W:0]   count_o
);

   localparam logic [ADDR_W-1:0] LP_START = ADDR_W'(START_DEF);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_FULL = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [8:0]        r_data;
   logic              r_done;
   logic              r_full;
   logic              r_err;

   logic [8:0]        w_enc;
   logic              w_legal;
   logic              w_ready;
   logic              w_accept;
   logic              w_wr;
   logic              w_at_top;

   // Instruction encoding; the 4-bit classes only have room for opnd[4:0].
   always_comb begin
      w_enc   = 9'd0;
      w_legal = 1'b0;
      case (beat.mnem_i)
         4'd0:  begin w_enc = {3'b000, beat.opnd_i};        w_legal = 1'b1;           end
         4'd1:  begin w_enc = {3'b001, beat.opnd_i};        w_legal = 1'b1;           end
         4'd2:  begin w_enc = {3'b010, beat.opnd_i};        w_legal = 1'b1;           end
         4'd3:  begin w_enc = {3'b011, beat.opnd_i};        w_legal = 1'b1;           end
         4'd4:  begin w_enc = {4'b1100, beat.opnd_i[4:0]};  w_legal = !beat.opnd_i[5]; end
         4'd5:  begin w_enc = {4'b1101, beat.opnd_i[4:0]};  w_legal = !beat.opnd_i[5]; end
         4'd6:  begin w_enc = {4'b1110, beat.opnd_i[4:0]};  w_legal = !beat.opnd_i[5]; end
         4'd7:  begin w_enc = {4'b1111, beat.opnd_i[4:0]};  w_legal = !beat.opnd_i[5]; end
         4'd8:  begin w_enc = {4'b1000, beat.opnd_i[4:0]};  w_legal = !beat.opnd_i[5]; end
         4'd9:  begin w_enc = {4'b1001, beat.opnd_i[4:0]};  w_legal = !beat.opnd_i[5]; end
         4'd10: begin w_enc = {4'b1010, beat.opnd_i[4:0]};  w_legal = !beat.opnd_i[5]; end
         4'd11: begin w_enc = {4'b1011, beat.opnd_i[4:0]};  w_legal = !beat.opnd_i[5]; end
         default: begin
            w_enc   = 9'd0;
            w_legal = 1'b0;
         end
      endcase
   end

   assign w_at_top = &r_ptr;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // start_i outranks a same-cycle beat, so ready drops while it is high.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = (r_state == S_RUN) && !start_i;
      w_accept    = w_ready && beat.in_valid_i;
      w_wr        = w_accept && w_legal;
      if (start_i) begin
         w_state_nxt = S_RUN;
      end else if (w_accept) begin
         if (beat.last_i) begin
            w_state_nxt = S_DONE;
         end else if (w_legal && w_at_top) begin
            w_state_nxt = S_FULL;
         end
      end
   end

   assign beat.in_ready_o = w_ready;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_ptr   <= LP_START;
         r_count <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= 9'd0;
         r_done  <= 1'b0;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_we   <= w_wr;
         r_done <= w_accept && beat.last_i;
         if (w_wr) begin
            r_addr <= r_ptr;
            r_data <= w_enc;
         end
         // A write already registered still issues after start; only the
         // bookkeeping is restarted here.
         if (start_i) begin
            r_ptr   <= start_addr_i;
            r_count <= '0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
         end else if (w_accept) begin
            if (w_legal) begin
               r_count <= r_count + 1'b1;
               if (w_at_top) begin
                  r_full <= 1'b1;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign mem_we_o   = r_we;
   assign mem_addr_o = r_addr;
   assign mem_data_o = r_data;
   assign done_o     = r_done;
   assign full_o     = r_full;
   assign err_o      = r_err;
   assign count_o    = r_count;

endmodule

// File: tb/tb_prog_encoder.sv
// Bench for prog_encoder: directed scenarios with literal expectations, then
// random beats checked every cycle against a transaction-level model.
module tb_prog_encoder;
   localparam int AW  = 3;
   localparam int TOP = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] saddr = '0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [8:0]    mem_data;
   logic          done, full, err;
   logic [AW:0]   count;

   prog_encoder_if bif ();

   prog_encoder #(.ADDR_W(AW), .START_DEF(2)) dut (
      .Clk          (clk),
      .Reset_n      (rst_n),
      .start_i      (start),
      .start_addr_i (saddr),
      .beat         (bif.slave),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_data_o   (mem_data),
      .done_o       (done),
      .full_o       (full),
      .err_o        (err),
      .count_o      (count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int enc(input int m, input int o);
      int p;
      if (m < 4) return m * 64 + o;
      case (m)
         4: p = 12;  5: p = 13;  6: p = 14;  7: p = 15;
         8: p = 8;   9: p = 9;   10: p = 10; default: p = 11;
      endcase
      return p * 32 + (o % 32);
   endfunction

   // Model: is the loader open for beats, where the next write goes, what
   // the registered outputs must show after the coming edge.
   bit m_open = 0;
   int m_ptr = 0, m_count = 0;
   bit m_err = 0, m_full = 0, e_we = 0, e_done = 0;
   int e_addr = 0, e_data = 0;

   initial begin
      bit acc, legal;
      int m, o;
      forever begin
         @(negedge clk);
         #1;
         chk("mem_we", mem_we, e_we);
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_data", mem_data, e_data);
         chk("done", done, e_done);
         chk("full", full, m_full);
         chk("err", err, m_err);
         chk("count", count, m_count);
         chk("in_ready", bif.in_ready_o, m_open && !start);
         m = int'(bif.mnem_i);
         o = int'(bif.opnd_i);
         acc = m_open && !start && bif.in_valid_i;
         e_we = 0;
         e_done = 0;
         if (!rst_n) begin
            m_open = 0; m_ptr = 2; m_count = 0; m_err = 0; m_full = 0;
            e_addr = 0; e_data = 0;
         end else if (start) begin
            m_open = 1; m_ptr = int'(saddr); m_count = 0; m_err = 0; m_full = 0;
         end else if (acc) begin
            legal = (m < 12) && !(m >= 4 && o >= 32);
            if (legal) begin
               e_we = 1; e_addr = m_ptr; e_data = enc(m, o);
               m_count++;
               if (m_ptr == TOP) begin m_full = 1; m_open = 0; end
               else m_ptr++;
            end else begin
               m_err = 1;
            end
            if (bif.last_i) begin e_done = 1; m_open = 0; end
         end
      end
   end

   task automatic drive(input bit r, input bit s, input int a, input bit v,
                        input int m, input int o, input bit l);
      @(negedge clk);
      rst_n = r;
      start = s;
      saddr = a[AW-1:0];
      bif.in_valid_i = v;
      bif.mnem_i = m[3:0];
      bif.opnd_i = o[5:0];
      bif.last_i = l;
   endtask

   task automatic idle();
      drive(1, 0, 0, 0, 0, 0, 0);
   endtask

   int lit_tab [12] = '{'h015, 'h055, 'h095, 'h0D5, 'h195, 'h1B5,
                        'h1D5, 'h1F5, 'h115, 'h135, 'h155, 'h175};

   initial begin
      bif.in_valid_i = 0; bif.mnem_i = 0; bif.opnd_i = 0; bif.last_i = 0;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_count", count, 0);
      idle();

      // LW then ADD(last) from address 0
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 1, 6'b011101, 0);
      drive(1, 0, 0, 1, 4, 6'b000111, 1);
      chk("s1_we0", mem_we, 1);
      chk("s1_addr0", mem_addr, 0);
      chk("s1_data0", mem_data, 'h05D);
      idle();
      chk("s1_addr1", mem_addr, 1);
      chk("s1_data1", mem_data, 'h187);
      chk("s1_done", done, 1);
      chk("s1_count", count, 2);
      idle();
      chk("s1_done_clr", done, 0);
      chk("s1_hold", mem_data, 'h187);

      // illegal PM and mnem 13, then COPY lands at unchanged ptr
      drive(1, 1, 2, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 11, 6'b100001, 0);
      drive(1, 0, 0, 1, 13, 0, 0);
      chk("s2_we", mem_we, 0);
      chk("s2_err", err, 1);
      drive(1, 0, 0, 1, 7, 6'b000010, 0);
      idle();
      chk("s2_addr", mem_addr, 2);
      chk("s2_data", mem_data, 'h1E2);
      chk("s2_count", count, 1);

      // memory top: third beat refused
      drive(1, 1, 6, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 1, 0);
      drive(1, 0, 0, 1, 0, 2, 0);
      drive(1, 0, 0, 1, 0, 3, 0);
      chk("s3_addr", mem_addr, 7);
      chk("s3_full", full, 1);
      #1 chk("s3_ready", bif.in_ready_o, 0);
      idle();
      chk("s3_we", mem_we, 0);
      chk("s3_count", count, 2);

      // start with valid high in RUN, pending write still issues
      drive(1, 1, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 9, 0);
      drive(1, 1, 4, 1, 0, 5, 1);
      chk("s4_pending", mem_addr, 1);
      idle();
      chk("s4_we", mem_we, 0);
      chk("s4_count", count, 0);
      drive(1, 0, 0, 1, 0, 7, 1);
      idle();
      chk("s4_addr", mem_addr, 4);

      // reset against an accepting edge cancels the write
      drive(1, 1, 3, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 5, 0);
      idle();
      chk("s5_we", mem_we, 0);
      chk("s5_data", mem_data, 0);
      chk("s5_addr", mem_addr, 0);

      for (int i = 0; i < 12; i++) begin
         drive(1, 1, 0, 0, 0, 0, 0);
         drive(1, 0, 0, 1, i, 6'b010101, 1);
         idle();
         chk($sformatf("enc_%0d", i), mem_data, lit_tab[i]);
      end

      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(99) != 0), ($urandom_range(11) == 0),
               int'($urandom_range(TOP)), ($urandom_range(9) < 6),
               ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(11)),
               int'($urandom_range(63)), ($urandom_range(9) == 0));
      end
      idle();
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
